// File: rtl/dct_rom_ctrl.sv
// DCT coefficient ROM controller: round-robin arbitration between two requesters,
// each grant walks one 8-entry row or column of the 8x8 coefficient ROM.
module dct_rom_ctrl #(
  parameter int DW = 24,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic [2:0]    row0,
  input  logic [2:0]    row1,
  input  logic          tr0,
  input  logic          tr1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rom_rd,
  output logic [AW-1:0] rom_add,
  input  logic [DW-1:0] rom_data,
  output logic          out_valid,
  output logic          out_id,
  output logic [2:0]    out_idx,
  output logic          out_last,
  output logic [15:0]   out_man,
  output logic [7:0]    out_exp,
  output logic          busy
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t        state, state_nx;
  logic [2:0]    cnt, cnt_nx;
  logic          ptr;
  logic [2:0]    cur_row;
  logic          cur_tr, cur_id;
  logic          grant, win_id;
  logic [AW-1:0] rd_addr;
  logic [1:0]    vld_pipe;
  logic [2:0]    rd_idx;
  logic          rd_id, rd_last;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    grant    = 1'b0;
    win_id   = 1'b0;
    case (state)
      IDLE: if (req0 || req1) begin
        grant    = 1'b1;
        // on a tie the requester not served last wins
        win_id   = (req0 && req1) ? ~ptr : req1;
        cnt_nx   = 3'd0;
        state_nx = BURST;
      end
      BURST: begin
        cnt_nx = cnt + 3'd1;
        if (cnt == 3'd7) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign rd_addr = cur_tr ? AW'({cnt, cur_row}) : AW'({cur_row, cnt});

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      ptr      <= 1'b1;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      cur_row  <= 3'd0;
      cur_tr   <= 1'b0;
      cur_id   <= 1'b0;
      vld_pipe <= 2'b00;
      rom_add  <= '0;
      rd_idx   <= 3'd0;
      rd_id    <= 1'b0;
      rd_last  <= 1'b0;
      out_idx  <= 3'd0;
      out_id   <= 1'b0;
      out_last <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      gnt0  <= grant & ~win_id;
      gnt1  <= grant & win_id;
      if (grant) begin
        ptr     <= win_id;
        cur_row <= win_id ? row1 : row0;
        cur_tr  <= win_id ? tr1 : tr0;
        cur_id  <= win_id;
      end
      // stage 0: ROM read issue; address holds between bursts
      vld_pipe[0] <= (state == BURST);
      if (state == BURST) begin
        rom_add <= rd_addr;
        rd_idx  <= cnt;
        rd_id   <= cur_id;
        rd_last <= (cnt == 3'd7);
      end
      // stage 1: aligned with rom_data returning
      vld_pipe[1] <= vld_pipe[0];
      out_idx     <= rd_idx;
      out_id      <= rd_id;
      out_last    <= vld_pipe[0] & rd_last;
    end
  end

  assign rom_rd    = vld_pipe[0];
  assign out_valid = vld_pipe[1];
  assign busy      = (state == BURST);
  assign out_man   = rom_data[DW-1:8];
  assign out_exp   = rom_data[7:0];

endmodule

// File: tb/tb_dct_rom_ctrl.sv
// Directed bench for dct_rom_ctrl: ROM model plus beat/grant scoreboards.
module tb_dct_rom_ctrl;
  logic        clk, rst;
  logic        req0, req1, tr0, tr1;
  logic [2:0]  row0, row1;
  logic        gnt0, gnt1, rom_rd;
  logic [5:0]  rom_add;
  logic [23:0] rom_data;
  logic        out_valid, out_id, out_last, busy;
  logic [2:0]  out_idx;
  logic [15:0] out_man;
  logic [7:0]  out_exp;

  dct_rom_ctrl #(.DW(24), .AW(6)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .row0(row0), .row1(row1),
    .tr0(tr0), .tr1(tr1), .gnt0(gnt0), .gnt1(gnt1), .rom_rd(rom_rd),
    .rom_add(rom_add), .rom_data(rom_data), .out_valid(out_valid),
    .out_id(out_id), .out_idx(out_idx), .out_last(out_last),
    .out_man(out_man), .out_exp(out_exp), .busy(busy)
  );

  typedef struct {
    logic        id;
    logic [2:0]  idx;
    logic        last;
    logic [5:0]  addr;
    logic [23:0] data;
  } beat_t;

  logic [23:0] mem [64];
  beat_t       sb[$];
  logic        gq[$];
  int          gcyc[$];
  int          tests, fails, cyc, gnt_cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (rom_rd) rom_data <= mem[rom_add];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_burst(input logic id, input logic [2:0] row, input logic tr);
    beat_t b;
    for (int k = 0; k < 8; k++) begin
      b.id   = id;
      b.idx  = 3'(k);
      b.last = (k == 7);
      b.addr = tr ? {3'(k), row} : {row, 3'(k)};
      b.data = mem[b.addr];
      sb.push_back(b);
    end
    gq.push_back(id);
  endtask

  task automatic step();
    beat_t b;
    logic  e;
    @(posedge clk);
    #1;
    cyc++;
    if (out_valid) begin
      if (sb.size() == 0) chk("spurious_beat", 32'(out_valid), 32'd0);
      else begin
        b = sb.pop_front();
        chk("beat_id",   32'(out_id),   32'(b.id));
        chk("beat_idx",  32'(out_idx),  32'(b.idx));
        chk("beat_last", 32'(out_last), 32'(b.last));
        chk("beat_man",  32'(out_man),  32'(b.data[23:8]));
        chk("beat_exp",  32'(out_exp),  32'(b.data[7:0]));
        if (b.idx == 3'd0) chk("lat_first", 32'(cyc - gnt_cyc), 32'd2);
        if (b.idx == 3'd7) chk("lat_last",  32'(cyc - gnt_cyc), 32'd9);
        if (b.addr == 6'd18) begin
          chk("preload_man", 32'(out_man), 32'h4000);
          chk("preload_exp", 32'(out_exp), 32'hFE);
        end
      end
    end
    if (gnt0 || gnt1) begin
      if (gq.size() == 0) chk("spurious_gnt", 32'({gnt1, gnt0}), 32'd0);
      else begin
        e = gq.pop_front();
        chk("gnt_onehot", 32'({gnt1, gnt0}), e ? 32'd2 : 32'd1);
        gnt_cyc = cyc;
        gcyc.push_back(cyc);
      end
      if (gnt0) req0 = 1'b0;
      if (gnt1) req1 = 1'b0;
    end
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((sb.size() > 0 || gq.size() > 0) && n < max) begin
      step();
      n++;
    end
    chk("drain_timeout", 32'(sb.size() + gq.size()), 32'd0);
    repeat (2) step();
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0; gnt_cyc = 0;
    req0 = 0; req1 = 0; row0 = 0; row1 = 0; tr0 = 0; tr1 = 0; rst = 1;
    for (int a = 0; a < 64; a++) mem[a] = {16'h1000 + 16'(a) * 16'h0111, 8'h80 ^ 8'(a)};
    mem[18] = 24'h4000FE;

    // reset state
    repeat (2) step();
    chk("rst_outs", 32'({rom_rd, gnt0, gnt1, out_valid, out_last, busy}), 32'd0);
    chk("rst_add",  32'(rom_add), 32'd0);
    chk("rst_idid", 32'({out_idx, out_id}), 32'd0);
    rst = 0;

    // row 2 walk, including preloaded address 18
    req0 = 1; row0 = 3'd2; tr0 = 0;
    push_burst(1'b0, 3'd2, 1'b0);
    step();
    chk("busy_burst", 32'(busy), 32'd1);
    drain(40);
    chk("add_hold", 32'(rom_add), 32'd23);
    chk("idle_rd",  32'({rom_rd, busy}), 32'd0);

    // column 5 walk for requester 1
    req1 = 1; row1 = 3'd5; tr1 = 1;
    push_burst(1'b1, 3'd5, 1'b1);
    drain(40);

    // tie with pointer pointing at requester 1 -> 0 first, 1 nine cycles later
    gcyc.delete();
    req0 = 1; row0 = 3'd0; tr0 = 0; req1 = 1; row1 = 3'd7; tr1 = 1;
    push_burst(1'b0, 3'd0, 1'b0);
    push_burst(1'b1, 3'd7, 1'b1);
    drain(60);
    chk("tie_gap", 32'(gcyc[1] - gcyc[0]), 32'd9);
    // third tie goes back to requester 0
    req0 = 1; row0 = 3'd6; tr0 = 1; req1 = 1; row1 = 3'd1; tr1 = 0;
    push_burst(1'b0, 3'd6, 1'b1);
    push_burst(1'b1, 3'd1, 1'b0);
    drain(60);

    // reset at beat 4 aborts the burst
    req0 = 1; row0 = 3'd3; tr0 = 0;
    push_burst(1'b0, 3'd3, 1'b0);
    for (int n = 0; n < 30 && sb.size() > 3; n++) step();
    chk("beat4_reached", 32'(sb.size()), 32'd3);
    rst = 1;
    step();
    sb.delete();
    chk("abort_outs", 32'({out_valid, rom_rd, busy}), 32'd0);
    rst = 0;
    repeat (12) step();
    req0 = 1; row0 = 3'd1; tr0 = 1;
    push_burst(1'b0, 3'd1, 1'b1);
    drain(40);

    // short req1 pulse during a burst: ignored, pointer stays at requester 0
    req0 = 1; row0 = 3'd4; tr0 = 0;
    push_burst(1'b0, 3'd4, 1'b0);
    for (int n = 0; n < 10 && gq.size() > 0; n++) step();
    step();
    req1 = 1; row1 = 3'd2; tr1 = 0;
    step();
    req1 = 0;
    drain(40);
    req0 = 1; row0 = 3'd7; tr0 = 0; req1 = 1; row1 = 3'd3; tr1 = 1;
    push_burst(1'b1, 3'd3, 1'b1);
    push_burst(1'b0, 3'd7, 1'b0);
    drain(60);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dct_rom_ctrl.md
DCT_ROM_CTRL -- requirements
Module: dct_rom_ctrl

Interface
REQ-001 Parameter: DW, 24, ROM data width; bits [DW-1:8] are the signed mantissa and bits [7:0] are the signed exponent.
REQ-002 Parameter: AW, 6, ROM address width; the ROM holds 64 coefficients as an 8x8 matrix, row-major.
REQ-003 Port: clk  in  1  single clock; all logic is on the rising edge.
REQ-004 Port: rst  in  1  reset, synchronous, active-high.
REQ-005 Port: req0, req1  in  1 each  burst request from requester 0 and requester 1; held high until granted.
REQ-006 Port: row0, row1  in  3 each  matrix row/column index for each requester.
REQ-007 Port: tr0, tr1  in  1 each  transpose select (0 = row k walk, 1 = column k walk).
REQ-008 Port: gnt0, gnt1  out  1 each  one-cycle grant pulse.
REQ-009 Port: rom_rd  out  1  ROM read enable.
REQ-010 Port: rom_add  out  AW  ROM address.
REQ-011 Port: rom_data  in  DW  ROM data, valid one cycle after rom_rd.
REQ-012 Port: out_valid  out  1  coefficient beat valid.
REQ-013 Port: out_id  out  1  requester owning the beat.
REQ-014 Port: out_idx  out  3  beat index 0..7 within the burst.
REQ-015 Port: out_last  out  1  high with beat 7.
REQ-016 Port: out_man  out  16  mantissa field of rom_data.
REQ-017 Port: out_exp  out  8  exponent field of rom_data.
REQ-018 Port: busy  out  1  high in BURST.

Function
REQ-019 The FSM SHALL have two states: IDLE and BURST.
REQ-020 In IDLE with any req high, the block SHALL pulse exactly one gnt, latch that requester's row, tr and id, clear cnt and enter BURST on the next edge.
REQ-021 Arbitration SHALL be round-robin on a last-served pointer; when both requests are high, the requester not last served wins; the pointer updates on each grant.
REQ-022 In BURST, rom_rd SHALL be 1 every cycle, cnt SHALL increment by 1, and rom_add SHALL be {row,cnt} when tr=0 and {cnt,row} when tr=1.
REQ-023 When cnt=7 in BURST, the FSM SHALL return to IDLE; no grant is issued in a BURST cycle.
REQ-024 Back-to-back bursts SHALL therefore be 9 cycles apart (grant cycle plus 8 reads).
REQ-025 out_valid, out_id, out_idx and out_last SHALL equal rom_rd, the latched id, cnt and (cnt==7), each delayed by one register stage.
REQ-026 out_man and out_exp SHALL be combinational slices of rom_data.
REQ-027 The first out_valid SHALL occur 2 cycles after gnt; the last SHALL occur 9 cycles after gnt.
REQ-028 A req that drops before it is granted SHALL be ignored, with no grant and no pointer change.
REQ-029 rom_add SHALL hold its last value when rom_rd=0.
REQ-030 Downstream SHALL accept every beat; there is no backpressure, and the data stream never pauses within a burst.

Reset
REQ-031 While rst=1, the block SHALL force state=IDLE, cnt=0, pointer=1 (so requester 0 wins the first tie), and set rom_rd, gnt0, gnt1, out_valid, out_last, busy, rom_add, out_idx and out_id to 0.
REQ-032 Reset asserted mid-burst SHALL abort the burst; out_valid SHALL be 0 on the cycle after rst is sampled, and no partial beats SHALL resume afterwards.
REQ-033 The first grant after rst deasserts SHALL be possible on the first edge at which rst=0 is sampled and a req is high.

Verification
REQ-034 Scenario: req0=1, row0=2, tr0=0 -> gnt0 pulses; rom_add = 16..23 on consecutive cycles; out_idx 0..7, out_id=0, out_last on idx 7.
REQ-035 Scenario: req1=1, row1=5, tr1=1 -> rom_add sequence is 5,13,21,...,61; out_id=1.
REQ-036 Scenario: req0 and req1 high together after reset -> gnt0 first; gnt1 exactly 9 cycles later; a third tie grants requester 0 again.
REQ-037 Scenario: ROM preloaded with 0x4000_FE at the address under test -> out_man=0x4000 and out_exp=0xFE on that beat.
REQ-038 Scenario: rst pulsed at burst beat 4 -> no further out_valid; a subsequent req0 yields a full 8-beat burst starting at idx 0.
REQ-039 Scenario: req1 pulsed 1 cycle while a burst is in progress and dropped before IDLE -> no gnt1, and the pointer is unchanged.
